i2c_reg_sequencer: RTL and testbench

//   Upstream command sequencer for i2c_master. Accepts one register

---
 rtl/i2c_pkg.sv | 60 ++++++
 rtl/i2c_reg_sequencer.sv | 139 +++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Command encodings shared with i2c_master, plus the sequencer's state,
// step index and step-table types.
package i2c_pkg;

  localparam logic [2:0] START_CMD   = 3'd0;
  localparam logic [2:0] WR_CMD      = 3'd1;
  localparam logic [2:0] RD_CMD      = 3'd2;
  localparam logic [2:0] STOP_CMD    = 3'd3;
  localparam logic [2:0] RESTART_CMD = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_WAIT_RDY,
    S_RESP
  } seq_state_e;

  typedef logic [2:0] step_t;

  // Index of the closing STOP in the write and read step lists
  localparam step_t STEP_STOP_WR = 3'd4;
  localparam step_t STEP_STOP_RD = 3'd6;

  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] din;
    logic       last;
  } step_entry_t;

  function automatic step_entry_t mk_step(input logic [2:0] cmd, input logic [7:0] din,
                                          input logic last);
    step_entry_t e;
    e.cmd  = cmd;
    e.din  = din;
    e.last = last;
    return e;
  endfunction

  // Write: START, WR{dev,0}, WR reg, WR wdata, STOP
  // Read:  START, WR{dev,0}, WR reg, RESTART, WR{dev,1}, RD(nack last), STOP
  function automatic step_entry_t step_lookup(input logic rnw, input step_t step,
                                              input logic [6:0] dev, input logic [7:0] regb,
                                              input logic [7:0] wdata);
    step_entry_t e;
    e = mk_step(STOP_CMD, 8'h00, 1'b1);
    case (step)
      3'd0: e = mk_step(START_CMD, 8'h00, 1'b0);
      3'd1: e = mk_step(WR_CMD, {dev, 1'b0}, 1'b0);
      3'd2: e = mk_step(WR_CMD, regb, 1'b0);
      3'd3: e = rnw ? mk_step(RESTART_CMD, 8'h00, 1'b0) : mk_step(WR_CMD, wdata, 1'b0);
      3'd4: if (rnw) e = mk_step(WR_CMD, {dev, 1'b1}, 1'b0);
      3'd5: if (rnw) e = mk_step(RD_CMD, 8'h01, 1'b0);
      default: e = mk_step(STOP_CMD, 8'h00, 1'b1);
    endcase
    return e;
  endfunction

endpackage

// File: rtl/i2c_reg_sequencer.sv
// Front end for i2c_master: expands one register read/write request into the
// START/WR/RESTART/RD/STOP command stream and returns rdata plus a NACK flag.
module i2c_reg_sequencer
  import i2c_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rnw_i,
  input  logic [6:0] req_dev_i,
  input  logic [7:0] req_reg_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_nack_o,
  output logic [2:0] cmd_o,
  output logic [7:0] din_o,
  output logic       wr_i2c_o,
  input  logic       m_ready_i,
  input  logic       m_done_tick_i,
  input  logic       m_ack_i,
  input  logic [7:0] m_dout_i
);

  seq_state_e  state_q;
  step_t       step_q;
  step_t       step_d;
  logic        rnw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rd_q;
  logic        nack_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic        rsp_nack_q;
  logic [2:0]  cmd_q;
  logic [7:0]  din_q;
  logic        wr_i2c_q;

  step_entry_t ent;
  logic        ent_xfer;

  assign ent      = step_lookup(rnw_q, step_q, dev_q, reg_q, wdata_q);
  assign ent_xfer = (ent.cmd == WR_CMD) || (ent.cmd == RD_CMD);

  // Once a byte is NACKed the remaining bytes are skipped; STOP is still issued
  assign step_d = nack_q ? (rnw_q ? STEP_STOP_RD : STEP_STOP_WR) : step_q + 3'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      rnw_q       <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      nack_q      <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_nack_q  <= 1'b0;
      cmd_q       <= START_CMD;
      din_q       <= '0;
      wr_i2c_q    <= 1'b0;
    end else begin
      wr_i2c_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            rnw_q       <= req_rnw_i;
            dev_q       <= req_dev_i;
            reg_q       <= req_reg_i;
            wdata_q     <= req_wdata_i;
            step_q      <= '0;
            nack_q      <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_ready_i) begin
            cmd_q    <= ent.cmd;
            din_q    <= ent.din;
            wr_i2c_q <= 1'b1;
            state_q  <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (!m_ready_i) begin
            state_q <= ent_xfer ? S_WAIT_DONE : S_WAIT_RDY;
          end
        end
        S_WAIT_DONE: begin
          if (m_done_tick_i) begin
            if ((ent.cmd == WR_CMD) && m_ack_i) nack_q <= 1'b1;
            if (ent.cmd == RD_CMD) rd_q <= m_dout_i;
            state_q <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (m_ready_i) begin
            if (ent.last) begin
              // Response fields only change here so they stay stable between pulses
              rsp_valid_q <= 1'b1;
              rsp_nack_q  <= nack_q;
              if (rnw_q && !nack_q) rsp_rdata_q <= rd_q;
              state_q <= S_RESP;
            end else begin
              step_q  <= step_d;
              state_q <= S_ISSUE;
            end
          end
        end
        S_RESP: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_nack_o  = rsp_nack_q;
  assign cmd_o       = cmd_q;
  assign din_o       = din_q;
  assign wr_i2c_o    = wr_i2c_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural i2c_master + slave model, scoreboard
// of expected bus commands and responses.
module tb_i2c_reg_sequencer;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rnw = 1'b0;
  logic [6:0] req_dev = '0;
  logic [7:0] req_reg = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic [2:0] cmd;
  logic [7:0] din;
  logic       wr_i2c;
  logic       m_ready = 1'b1;
  logic       m_done_tick = 1'b0;
  logic       m_ack = 1'b0;
  logic [7:0] m_dout = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int strobes = 0;
  int rsp_cyc = 0;
  int rdy_cyc = 0;
  int viol = 0;

  logic [10:0] exp_bus[$];  // {cmd, din}
  logic [8:0]  exp_rsp[$];  // {nack, rdata}
  logic [7:0]  last_rdata = 8'h00;

  logic [6:0] slv_dev = 7'h50;
  int         slv_nack_wr = 0;
  logic [7:0] slv_rdata = 8'h00;
  int         wr_cnt = 0;
  bit         addr_phase = 1'b0;

  i2c_reg_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_rnw_i    (req_rnw),
    .req_dev_i    (req_dev),
    .req_reg_i    (req_reg),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_nack_o   (rsp_nack),
    .cmd_o        (cmd),
    .din_o        (din),
    .wr_i2c_o     (wr_i2c),
    .m_ready_i    (m_ready),
    .m_done_tick_i(m_done_tick),
    .m_ack_i      (m_ack),
    .m_dout_i     (m_dout)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  a_strobe_rdy: assert property (@(negedge clk) disable iff (!rst_n) !(wr_i2c && !m_ready));

  // Response monitor
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && wr_i2c && !m_ready) viol++;
      if (rst_n && rsp_valid) begin
        rsp_cyc = cyc;
        if (exp_rsp.size() == 0) check_val("rsp_extra", rsp_valid, 0);
        else begin
          e = exp_rsp.pop_front();
          check_val("rsp_nack", rsp_nack, e[8]);
          check_val("rsp_rdata", rsp_rdata, e[7:0]);
        end
      end
    end
  end

  task automatic m_abort();
    m_ready = 1'b1;
    m_done_tick = 1'b0;
  endtask

  // Behavioural i2c_master plus slave: ready drops after the strobe, byte
  // commands finish with a done tick.
  task automatic m_serve(input logic [2:0] c, input logic [7:0] d);
    logic [10:0] e;
    bit xfer;
    logic ack;
    strobes++;
    xfer = (c == WR_CMD) || (c == RD_CMD);
    if (exp_bus.size() == 0) check_val("bus_extra", wr_i2c, 0);
    else begin
      e = exp_bus.pop_front();
      check_val("bus_cmd", c, e[10:8]);
      if (xfer) check_val("bus_din", d, e[7:0]);
    end
    ack = 1'b1;
    if (c == START_CMD) begin wr_cnt = 0; addr_phase = 1'b1; end
    if (c == RESTART_CMD) addr_phase = 1'b1;
    if (c == WR_CMD) begin
      wr_cnt++;
      ack = (addr_phase && (d[7:1] != slv_dev)) || (wr_cnt == slv_nack_wr);
      addr_phase = 1'b0;
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (xfer ? 3 : 2) begin
      @(posedge clk); #1;
      if (!rst_n) begin m_abort(); return; end
    end
    if (xfer) begin
      m_ack = ack;
      m_dout = (c == RD_CMD) ? slv_rdata : 8'hFF;
      m_done_tick = 1'b1;
      @(posedge clk); #1;
      m_done_tick = 1'b0;
      if (!rst_n) begin m_abort(); return; end
      @(posedge clk); #1;
      if (!rst_n) begin m_abort(); return; end
    end
    m_ready = 1'b1;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n && wr_i2c) m_serve(cmd, din);
  end

  task automatic push_bus(input logic [2:0] c, input logic [7:0] d);
    exp_bus.push_back({c, d});
  endtask

  // nack_at: 0 none, 1 address byte, 2 register byte, 3 data byte
  task automatic exp_write(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                           input int nack_at);
    push_bus(START_CMD, 8'h00);
    push_bus(WR_CMD, {dev, 1'b0});
    if (nack_at != 1) push_bus(WR_CMD, rg);
    if (nack_at == 0 || nack_at == 3) push_bus(WR_CMD, wd);
    push_bus(STOP_CMD, 8'h00);
    exp_rsp.push_back({(nack_at != 0), last_rdata});
  endtask

  task automatic exp_read(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] rd);
    push_bus(START_CMD, 8'h00);
    push_bus(WR_CMD, {dev, 1'b0});
    push_bus(WR_CMD, rg);
    push_bus(RESTART_CMD, 8'h00);
    push_bus(WR_CMD, {dev, 1'b1});
    push_bus(RD_CMD, 8'h01);
    push_bus(STOP_CMD, 8'h00);
    last_rdata = rd;
    exp_rsp.push_back({1'b0, rd});
  endtask

  task automatic do_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd);
    bit ok;
    @(negedge clk);
    req_valid = 1'b1;
    req_rnw = rnw;
    req_dev = dev;
    req_reg = rg;
    req_wdata = wd;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      check_val("req_accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    rdy_cyc = cyc;
    @(negedge clk);
    // Scramble the request fields to show they were registered on accept
    req_valid = 1'b0;
    req_rnw = ~rnw;
    req_dev = ~dev;
    req_reg = ~rg;
    req_wdata = ~wd;
    check_val("lat_gap", wr_i2c, 0);
    @(negedge clk);
    check_val("lat_strobe", wr_i2c, 1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 3000 && exp_rsp.size() != 0; i++) @(negedge clk);
    check_val("rsp_pending", exp_rsp.size(), 0);
    repeat (6) @(negedge clk);
    check_val("bus_pending", exp_bus.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_ready"}, req_ready, 1);
    check_val({tag, "_rsp_valid"}, rsp_valid, 0);
    check_val({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check_val({tag, "_rsp_nack"}, rsp_nack, 0);
    check_val({tag, "_cmd"}, cmd, 0);
    check_val({tag, "_din"}, din, 0);
    check_val({tag, "_wr_i2c"}, wr_i2c, 0);
  endtask

  initial begin
    int s0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;

    // Plain write and read
    slv_rdata = 8'h3C;
    exp_write(7'h50, 8'h10, 8'hA5, 0);
    do_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_rsp();
    exp_read(7'h50, 8'h10, 8'h3C);
    do_req(1'b1, 7'h50, 8'h10, 8'h00);
    wait_rsp();

    // Address NACK, then data NACK
    exp_write(7'h51, 8'h22, 8'h5A, 1);
    do_req(1'b0, 7'h51, 8'h22, 8'h5A);
    wait_rsp();
    slv_nack_wr = 3;
    exp_write(7'h50, 8'h11, 8'h77, 3);
    do_req(1'b0, 7'h50, 8'h11, 8'h77);
    wait_rsp();
    slv_nack_wr = 0;

    slv_rdata = 8'hC3;
    exp_read(7'h50, 8'h20, 8'hC3);
    do_req(1'b1, 7'h50, 8'h20, 8'h00);
    wait_rsp();

    // A stray done tick while idle must not produce anything
    @(negedge clk);
    m_done_tick = 1'b1;
    m_ack = 1'b1;
    @(negedge clk);
    m_done_tick = 1'b0;
    m_ack = 1'b0;
    repeat (5) @(negedge clk);
    check_val("idle_ready", req_ready, 1);

    // Reset in the middle of a read, after the register byte
    slv_rdata = 8'h96;
    exp_read(7'h50, 8'h10, 8'h96);
    s0 = strobes;
    do_req(1'b1, 7'h50, 8'h10, 8'h00);
    for (int i = 0; i < 2000 && strobes < s0 + 3; i++) @(negedge clk);
    check_val("reg_byte_reached", strobes - s0, 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("arst");
    exp_bus.delete();
    exp_rsp.delete();
    last_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    exp_write(7'h50, 8'h30, 8'h5C, 0);
    do_req(1'b0, 7'h50, 8'h30, 8'h5C);
    wait_rsp();

    // Back-to-back: second request waits with valid held
    exp_write(7'h50, 8'h40, 8'h11, 0);
    exp_write(7'h50, 8'h41, 8'h22, 0);
    do_req(1'b0, 7'h50, 8'h40, 8'h11);
    do_req(1'b0, 7'h50, 8'h41, 8'h22);
    check_val("b2b_accept_cycle", rdy_cyc, rsp_cyc + 1);
    wait_rsp();

    check_val("strobe_while_busy", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
